// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: branch-type and FSM encodings,
// plus the branch target helper.
package branch_resolver_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BGT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLT  = 3'd5,
        BR_BLE  = 3'd6,
        BR_J    = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    // All arithmetic wraps modulo 2^32; J keeps the region bits of pc+4.
    function automatic logic [31:0] branch_target(input logic [2:0] br_type,
                                                  input logic [31:0] pc,
                                                  input logic [31:0] offset);
        logic [31:0] pc_plus4;
        pc_plus4 = pc + 32'd4;
        if (br_type == BR_J)
            branch_target = {pc_plus4[31:28], offset[25:0], 2'b00};
        else
            branch_target = pc_plus4 + (offset << 2);
    endfunction

endpackage

// File: rtl/branch_resolver_cond.sv
// Combinational branch condition: selects the ALU flag matching the branch type.
// Kept standalone so the hazard unit can reuse the same decision.
module branch_resolver_cond
    import branch_resolver_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic       beq_flag,
    input  logic       bne_flag,
    input  logic       bgt_flag,
    input  logic       bge_flag,
    input  logic       blt_flag,
    input  logic       ble_flag,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type_e'(br_type))
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = beq_flag;
            BR_BNE:  taken = bne_flag;
            BR_BGT:  taken = bgt_flag;
            BR_BGE:  taken = bge_flag;
            BR_BLT:  taken = blt_flag;
            BR_BLE:  taken = ble_flag;
            BR_J:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: decides taken/not-taken, issues a redirect to fetch, then
// holds flush for FLUSH_CYCLES cycles. Also keeps saturating branch statistics.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       br_type,
    input  logic [31:0]      pc,
    input  logic [31:0]      offset,
    input  logic             beq_flag,
    input  logic             bne_flag,
    input  logic             bgt_flag,
    input  logic             bge_flag,
    input  logic             blt_flag,
    input  logic             ble_flag,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // Counter is loaded with FLUSH_CYCLES-1 so flush is high exactly FLUSH_CYCLES cycles.
    localparam logic [3:0] FLUSH_INIT = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

    state_e            state_reg;
    logic [3:0]        flush_cnt_reg;
    logic              redirect_valid_reg;
    logic [31:0]       redirect_pc_reg;
    logic              flush_reg;
    logic [CNT_W-1:0]  stat_cnt_reg [2];

    logic              taken;
    logic              accept;
    logic [1:0]        stat_inc;

    branch_resolver_cond u_cond (
        .br_type  (br_type),
        .beq_flag (beq_flag),
        .bne_flag (bne_flag),
        .bgt_flag (bgt_flag),
        .bge_flag (bge_flag),
        .blt_flag (blt_flag),
        .ble_flag (ble_flag),
        .taken    (taken)
    );

    assign in_ready    = (state_reg == ST_IDLE);
    assign accept      = in_valid & in_ready;
    assign stat_inc[0] = accept & (br_type != BR_NONE);
    assign stat_inc[1] = accept & taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            flush_cnt_reg      <= 4'd0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= 32'd0;
            flush_reg          <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept && taken) begin
                        state_reg          <= ST_REDIRECT;
                        redirect_valid_reg <= 1'b1;
                        redirect_pc_reg    <= branch_target(br_type, pc, offset);
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid_reg <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg     <= ST_FLUSH;
                            flush_reg     <= 1'b1;
                            flush_cnt_reg <= FLUSH_INIT;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_reg == 4'd0) begin
                        flush_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Index 0 counts accepted branches, index 1 counts taken ones; both saturate.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            always_ff @(posedge clk) begin
                if (rst)
                    stat_cnt_reg[gi] <= '0;
                else if (stat_inc[gi] && (stat_cnt_reg[gi] != {CNT_W{1'b1}}))
                    stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign flush          = flush_reg;
    assign branch_cnt     = stat_cnt_reg[0];
    assign taken_cnt      = stat_cnt_reg[1];

endmodule
